// File: rtl/sensor_sample_sequencer.sv
// rtl/sensor_sample_sequencer.sv - periodic SPI light-sensor conversion scheduler with averaging into a circular sample buffer
module sensor_sample_sequencer #(
  parameter int SAMPLE_PERIOD = 100000,
  parameter int AVG_LOG2      = 2,
  parameter int ADDR_W        = 6,
  parameter int TIMEOUT       = 4096,
  parameter int GUARD         = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              enable,
  input  logic              start,
  input  logic              clr_err,
  output logic              spi_valid,
  input  logic              spi_ready,
  input  logic [7:0]        spi_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              timeout_err,
  output logic              overrun
);

  localparam int PER_W   = $clog2(SAMPLE_PERIOD);
  localparam int TMR_MAX = (TIMEOUT > GUARD) ? TIMEOUT : GUARD;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int SUM_W   = 8 + AVG_LOG2;
  localparam int CNT_W   = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(1 << AVG_LOG2);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_ACC, S_WRITE, S_GUARD} state_t;

  state_t             state, state_n;
  logic [2:0]         rdy_sync;
  logic               rdy_rise;
  logic [PER_W-1:0]   per_cnt;
  logic               tick;
  logic [TMR_W-1:0]   tmr;
  logic               pending;
  logic               trig_busy;
  logic               timeout_hit;
  logic [7:0]         sample;
  logic [SUM_W-1:0]   sum;
  logic [CNT_W-1:0]   cnt;

  // Only a fresh synchronized rising edge counts, so a level left high from a prior transaction is ignored.
  assign rdy_rise  = rdy_sync[1] & ~rdy_sync[2];
  assign tick      = enable && (per_cnt == PER_W'(SAMPLE_PERIOD - 1));
  assign trig_busy = (tick || start) && (state != S_IDLE);
  assign mem_wdata = 8'(sum >> AVG_LOG2);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n     = state;
    spi_valid   = 1'b0;
    mem_we      = 1'b0;
    timeout_hit = 1'b0;
    busy        = (state != S_IDLE);
    case (state)
      S_IDLE:  if (tick || start || pending) state_n = S_REQ;
      S_REQ: begin
        spi_valid = 1'b1;
        if (rdy_rise) begin
          state_n = S_ACC;
        end else if (tmr == TMR_W'(TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          state_n     = S_GUARD;
        end
      end
      S_ACC:   state_n = ((cnt + CNT_W'(1)) == CNT_FULL) ? S_WRITE : S_GUARD;
      S_WRITE: begin
        mem_we  = 1'b1;
        state_n = S_GUARD;
      end
      S_GUARD: if (tmr == TMR_W'(GUARD - 1)) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdy_sync    <= '0;
      per_cnt     <= '0;
      tmr         <= '0;
      pending     <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
      sample      <= '0;
      sum         <= '0;
      cnt         <= '0;
      mem_addr    <= '0;
    end else begin
      rdy_sync <= {rdy_sync[1:0], spi_ready};
      per_cnt  <= (!enable || tick) ? '0 : per_cnt + PER_W'(1);
      // One timer serves both the REQ timeout and the GUARD spacing; it restarts on every state change.
      tmr      <= (state_n != state || state == S_IDLE) ? '0 : tmr + TMR_W'(1);

      if (state == S_IDLE && state_n == S_REQ) pending <= 1'b0;
      else if (trig_busy)                      pending <= 1'b1;

      if (trig_busy && pending) overrun <= 1'b1;
      else if (clr_err)         overrun <= 1'b0;

      if (timeout_hit)  timeout_err <= 1'b1;
      else if (clr_err) timeout_err <= 1'b0;

      if (state == S_REQ && rdy_rise) sample <= spi_data;

      if (state == S_ACC) begin
        sum <= sum + SUM_W'(sample);
        cnt <= cnt + CNT_W'(1);
      end else if (state == S_WRITE || timeout_hit) begin
        sum <= '0;
        cnt <= '0;
      end

      if (state == S_WRITE) mem_addr <= mem_addr + ADDR_W'(1);
    end
  end

endmodule

// File: doc/sensor_sample_sequencer.md
Name: sensor_sample_sequencer

Overview:
- Schedules periodic conversions on the 8-bit SPI light-sensor reader by driving its valid line and waiting for its ready line.
- Averages 2^AVG_LOG2 consecutive samples and writes each average into a circular sample memory.
- Sits between the system timebase/control registers and the SPI reader + sample RAM.
- Owns transaction spacing, timeout recovery and error/overrun flags.

Parameters:
- SAMPLE_PERIOD, 100000: clk cycles between periodic conversion triggers (≥ 2).
- AVG_LOG2, 2: log2 of samples per average, 0..4. 0 writes every raw sample.
- ADDR_W, 6: sample memory address width. The buffer holds 2^ADDR_W entries.
- TIMEOUT, 4096: max clk cycles from valid rise to ready rise.
- GUARD, 16: clk cycles valid stays low between transactions. Lets the reader deselect its slave.

Ports:
- clk, in, 1: system clock.
- rstn, in, 1: asynchronous active-low reset.
- enable, in, 1: 1 = periodic sampling runs.
- start, in, 1: one-cycle pulse requesting a single conversion; honoured in IDLE regardless of enable.
- clr_err, in, 1: pulse; clears timeout_err and overrun.
- spi_valid, out, 1: conversion request to the SPI reader.
- spi_ready, in, 1: reader completion level (asynchronous to clk domain edges).
- spi_data, in, 8: reader result; stable while spi_ready high.
- mem_we, out, 1: one-cycle write strobe.
- mem_addr, out, ADDR_W: write address.
- mem_wdata, out, 8: averaged sample.
- busy, out, 1: 1 in any state other than IDLE.
- timeout_err, out, 1: sticky, set on a transaction timeout.
- overrun, out, 1: sticky, set when a trigger arrives while one is already pending.

Behaviour:
- Reset values: all outputs 0, mem_addr 0, accumulator 0, sample count 0, period counter 0, pending 0, state IDLE.
- spi_ready passes through a 2-flop synchronizer. Completion is the synchronized rising edge only, so a stale high level left from a prior transaction is ignored.
- Period counter:
  - Counts 0..SAMPLE_PERIOD-1 while enable=1 and wraps to 0.
  - Emits a tick on the wrap.
  - Forced to 0 while enable=0.
- Trigger = tick, or start while in IDLE.
  - Trigger while not IDLE: if pending=0, set pending=1; if pending=1, set overrun=1.
- States:
  - IDLE: on trigger or pending, clear pending, go to REQ.
  - REQ:
    - spi_valid=1 and timeout counter running.
    - On completion edge: latch spi_data, drop spi_valid next cycle, go to ACC.
    - If the counter reaches TIMEOUT first: drop spi_valid, set timeout_err, clear accumulator and sample count, go to GUARD.
  - ACC:
    - sum += sample. The sum is 8+AVG_LOG2 bits wide and cannot overflow.
    - Sample count increments.
    - If count reaches 2^AVG_LOG2, go to WRITE; else go to GUARD.
  - WRITE:
    - mem_we=1 for exactly 1 cycle.
    - mem_wdata = sum >> AVG_LOG2 (truncating).
    - mem_addr = current address; the address then increments mod 2^ADDR_W (2^ADDR_W-1 wraps to 0).
    - Clear sum and count, go to GUARD.
  - GUARD: spi_valid=0 for GUARD cycles, then go to IDLE.
- Latency: completion edge (synchronized) to mem_we is 2 cycles when a write is due.
- enable falling mid-transaction: the current transaction completes normally; no new ticks are generated.
  - A pending trigger already latched is still served.
  - A partial average is retained and resumes when enable returns.
- start while busy follows the same pending/overrun rule as a tick.
- Simultaneous clr_err and a set event in the same cycle: set wins.
- rstn low at any time: immediate return to reset values. spi_valid drops asynchronously.
- spi_valid never rises less than GUARD cycles after its last fall.

Test Plan:
- AVG_LOG2=2, enable=1, reader model returns 0x10, 0x20, 0x30, 0x41 -> exactly one mem_we with mem_wdata=0x28 (0xA1>>2), mem_addr=0, then mem_addr=1 next.
- AVG_LOG2=0, ADDR_W=2, 5 conversions returning 1..5 -> writes at addresses 0,1,2,3,0. The last write has data 5 (wrap check).
- Reader never raises ready -> spi_valid falls after TIMEOUT cycles and timeout_err=1. The next conversion starts after GUARD cycles. clr_err clears the flag.
- SAMPLE_PERIOD=20, reader latency 50 cycles -> first extra tick sets pending with no overrun; a second tick in the same transaction sets overrun=1. The pending conversion runs right after GUARD.
- enable=0, start pulse in IDLE -> exactly one REQ/ACC cycle and busy returns to 0. A stale spi_ready held high before start is not taken as completion.
- rstn asserted during REQ -> spi_valid=0 and busy=0 immediately, mem_addr=0. After release there is no activity until a trigger.
